bcd_counter_scan: RTL and testbench
===================================

BCD_COUNTER_SCAN -- requirements
Module: bcd_counter_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit is held active during scanning (legal range 1..2^20).
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit, count enable; one count step per cycle sampled high.
REQ-005 SHALL have port up, input, 1 bit, direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port clr, input, 1 bit, synchronous clear of the count to 0000.
REQ-007 SHALL have port blank_lz, input, 1 bit, leading-zero blanking enable.
REQ-008 SHALL have port value, output, 16 bits, packed BCD count {d3,d2,d1,d0}, d0 least significant.
REQ-009 SHALL have port wrap, output, 1 bit, one-cycle pulse on count wrap-around.
REQ-010 SHALL have port bcd, output, 4 bits, BCD digit currently scanned; feeds the 7-segment decoder.
REQ-011 SHALL have port an, output, 4 bits, active-low digit enables; an[i] selects digit i.

Function
REQ-012 SHALL hold four BCD digit registers d0..d3, each always in range 0..9.
REQ-013 SHALL, when en=1, up=1 and clr=0, increment with decimal carry (d0 9->0 carries into d1, etc.); the new value appears on value the next cycle.
REQ-014 SHALL, when en=1, up=0 and clr=0, decrement with decimal borrow (d0 0->9 borrows from d1, etc.).
REQ-015 SHALL wrap 9999 -> 0000 on increment and 0000 -> 9999 on decrement, asserting wrap for exactly the cycle in which the wrapped value is first presented on value.
REQ-016 SHALL keep wrap low in every other cycle, including during clear.
REQ-017 SHALL give clr priority over en: clr=1 loads 0000 next cycle regardless of en/up.
REQ-018 SHALL hold the count unchanged when en=0 and clr=0.
REQ-019 SHALL contain a prescaler counting 0..REFRESH_DIV-1; on the cycle it equals REFRESH_DIV-1 it returns to 0 and the scan index advances 0->1->2->3->0.
REQ-020 SHALL, with REFRESH_DIV=1, advance the scan index every cycle.
REQ-021 SHALL drive an and bcd combinationally from the registered scan index and digit registers: an = all ones except bit[index] = 0, bcd = d[index].
REQ-022 SHALL, when blank_lz=1, blank digit i (i=1..3) if d[i] and every higher digit are 0; digit 0 is never blanked.
REQ-023 SHALL, for a blanked digit in its scan slot, drive an = 4'b1111 and bcd = 4'hF (a non-decimal code the decoder renders all segments off).
REQ-024 SHALL apply blanking from current digit values, so blanking follows count changes in the same cycle value changes.
REQ-025 SHALL keep scanning independent of en, up, clr and blank_lz; the prescaler and index are not disturbed by counting or clearing.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, load d0..d3 = 0, prescaler = 0, scan index = 0, wrap = 0; rst overrides clr and en.
REQ-027 SHALL present after reset: value = 16'h0000, wrap = 0, an = 4'b1110, bcd = 4'h0 (digit 0 unblanked even with blank_lz=1).
REQ-028 SHALL, on reset asserted mid-count or mid-scan, abandon the operation with no wrap pulse and restart scanning from digit 0 with a full REFRESH_DIV period.

Verification
REQ-029 Increment carry: REFRESH_DIV=4, value=0999, en=1, up=1 one cycle -> value=1000 next cycle, wrap=0.
REQ-030 Wrap both ways: value=9999, up=1, en=1 one cycle -> value=0000 with wrap=1 for one cycle; then up=0, en=1 one cycle -> value=9999 with wrap=1 for one cycle.
REQ-031 Priority: value=0042, clr=1, en=1, up=1 same cycle -> value=0000, wrap=0; rst=1 with clr=0, en=1 -> value=0000.
REQ-032 Scan timing: REFRESH_DIV=3, value=1234, blank_lz=0, after reset -> an sequence 1110,1101,1011,0111 each held 3 cycles with bcd 4,3,2,1; then repeats.
REQ-033 Blanking: value=0007, blank_lz=1 -> slot 0 an=1110, bcd=7; slots 1-3 an=1111, bcd=F; value=0000 -> slot 0 shows bcd=0; value=0107 -> only digit 3 blanked.
REQ-034 Reset mid-scan: REFRESH_DIV=4, rst pulsed during slot 2 -> next cycle an=1110, bcd=d0, slot held 4 cycles, value=0000.

Source files
------------

// File: rtl/bcd_counter_scan.sv
// Four-digit up/down BCD counter with a multiplexed 7-segment scan driver.
// The prescaler and scan index run continuously, independent of counting and clearing.
module bcd_counter_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        blank_lz,
    output logic [15:0] value,
    output logic        wrap,
    output logic [3:0]  bcd,
    output logic [3:0]  an
);

    localparam logic [19:0] PRESC_MAX = 20'(REFRESH_DIV - 1);

    logic [3:0]  d      [4];
    logic [3:0]  d_next [4];
    logic        carry;
    logic        wrap_next;
    logic [19:0] presc;
    logic [1:0]  idx;
    logic [3:0]  blank;

    // Ripple the carry/borrow through the digits; a carry out of d3 means the count wrapped.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d_next[i] = d[i];
            if (carry) begin
                if (up) begin
                    if (d[i] == 4'd9) begin
                        d_next[i] = 4'd0;
                    end else begin
                        d_next[i] = d[i] + 4'd1;
                        carry     = 1'b0;
                    end
                end else begin
                    if (d[i] == 4'd0) begin
                        d_next[i] = 4'd9;
                    end else begin
                        d_next[i] = d[i] - 4'd1;
                        carry     = 1'b0;
                    end
                end
            end
        end
        wrap_next = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) d[i] <= 4'd0;
            wrap  <= 1'b0;
            presc <= 20'd0;
            idx   <= 2'd0;
        end else begin
            wrap <= 1'b0;
            if (clr) begin
                for (int i = 0; i < 4; i++) d[i] <= 4'd0;
            end else if (en) begin
                for (int i = 0; i < 4; i++) d[i] <= d_next[i];
                wrap <= wrap_next;
            end
            if (presc == PRESC_MAX) begin
                presc <= 20'd0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 20'd1;
            end
        end
    end

    // A digit is blanked only when it and every digit above it are zero.
    always_comb begin
        blank[0] = 1'b0;
        blank[3] = blank_lz && (d[3] == 4'd0);
        blank[2] = blank[3] && (d[2] == 4'd0);
        blank[1] = blank[2] && (d[1] == 4'd0);
    end

    always_comb begin
        if (blank[idx]) begin
            an  = 4'b1111;
            bcd = 4'hF;
        end else begin
            an  = ~(4'b0001 << idx);
            bcd = d[idx];
        end
    end

    assign value = {d[3], d[2], d[1], d[0]};

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Bench for bcd_counter_scan: an integer count plus a cycles-since-reset counter
// model the expected count, wrap pulse and scanned digit.
module tb_bcd_counter_scan;

  localparam int DIV = 3;

  logic        clk = 1'b0;
  logic        rst, en, up, clr, blank_lz;
  logic [15:0] value, value1;
  logic        wrap, wrap1;
  logic [3:0]  bcd, an, bcd1, an1;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int ticks = 0;
  logic m_wrap = 1'b0;
  logic [15:0] exp_q[$];
  logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  bcd_counter_scan #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .blank_lz(blank_lz),
    .value(value), .wrap(wrap), .bcd(bcd), .an(an)
  );

  bcd_counter_scan #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .blank_lz(blank_lz),
    .value(value1), .wrap(wrap1), .bcd(bcd1), .an(an1)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic int slot_of(input int div);
    return (ticks / div) % 4;
  endfunction

  function automatic logic is_blank(input int slot);
    return blank_lz && slot > 0 && m_cnt < pow10(slot);
  endfunction

  function automatic logic [3:0] exp_an(input int slot);
    return is_blank(slot) ? 4'b1111 : an_tab[slot];
  endfunction

  function automatic logic [3:0] exp_bcd(input int slot);
    return is_blank(slot) ? 4'hF : 4'(m_cnt / pow10(slot) % 10);
  endfunction

  // Drive one clock of inputs and advance the model; returns #1 after the edge.
  task automatic step(input logic r, input logic e, input logic u, input logic c);
    rst = r; en = e; up = u; clr = c;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_wrap = 1'b0; ticks = 0;
    end else begin
      ticks++;
      m_wrap = 1'b0;
      if (c) m_cnt = 0;
      else if (e && u) begin
        m_wrap = (m_cnt == 9999);
        m_cnt = (m_cnt + 1) % 10000;
      end else if (e) begin
        m_wrap = (m_cnt == 0);
        m_cnt = (m_cnt + 9999) % 10000;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    blank_lz = 1'b1;
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL reset_value got=%h exp=0000", value); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    checks++; if (an !== 4'b1110) begin failures++; $display("FAIL reset_an got=%b exp=1110", an); end
    checks++; if (bcd !== 4'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
  endtask

  task automatic test_wrap;
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++; if (value !== 16'h9999) begin failures++; $display("FAIL wrap_dn_value got=%h exp=9999", value); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_dn_pulse got=%b exp=1", wrap); end
    step(0, 1, 1, 0);
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL wrap_up_value got=%h exp=0000", value); end
    checks++; if (wrap !== 1'b1) begin failures++; $display("FAIL wrap_up_pulse got=%b exp=1", wrap); end
    step(0, 0, 1, 0);
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL wrap_after_pulse got=%b exp=0", wrap); end
  endtask

  task automatic test_carry;
    step(0, 0, 0, 1);
    for (int i = 0; i < 999; i++) begin
      step(0, 1, 1, 0);
      checks++; if (value !== to_bcd(m_cnt) || wrap !== 1'b0) begin
        failures++; $display("FAIL carry_count got=%h/%b exp=%h/0", value, wrap, to_bcd(m_cnt));
      end
    end
    checks++; if (value !== 16'h0999) begin failures++; $display("FAIL carry_0999 got=%h exp=0999", value); end
    step(0, 1, 1, 0);
    checks++; if (value !== 16'h1000) begin failures++; $display("FAIL carry_1000 got=%h exp=1000", value); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL carry_wrap got=%b exp=0", wrap); end
  endtask

  task automatic test_priority;
    step(0, 0, 0, 1);
    for (int i = 0; i < 42; i++) step(0, 1, 1, 0);
    checks++; if (value !== 16'h0042) begin failures++; $display("FAIL prio_0042 got=%h exp=0042", value); end
    step(0, 1, 1, 1);
    checks++; if (value !== 16'h0000 || wrap !== 1'b0) begin failures++; $display("FAIL prio_clr got=%h/%b exp=0000/0", value, wrap); end
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    checks++; if (value !== 16'h0000 || wrap !== 1'b0) begin failures++; $display("FAIL prio_clr_at_9999 got=%h/%b exp=0000/0", value, wrap); end
    for (int i = 0; i < 42; i++) step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    checks++; if (value !== 16'h0000 || wrap !== 1'b0) begin failures++; $display("FAIL prio_rst got=%h/%b exp=0000/0", value, wrap); end
    step(0, 0, 1, 0);
    checks++; if (value !== 16'h0000) begin failures++; $display("FAIL hold_zero got=%h exp=0000", value); end
  endtask

  task automatic test_scan;
    blank_lz = 1'b0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 1234; i++) step(0, 1, 1, 0);
    checks++; if (value !== 16'h1234) begin failures++; $display("FAIL scan_value got=%h exp=1234", value); end
    for (int i = 0; i < 4 * DIV * 2; i++) begin
      step(0, 0, $urandom_range(0, 1), 0);
      checks++; if (an !== exp_an(slot_of(DIV)) || bcd !== exp_bcd(slot_of(DIV))) begin
        failures++; $display("FAIL scan_slot got=%b/%h exp=%b/%h", an, bcd, exp_an(slot_of(DIV)), exp_bcd(slot_of(DIV)));
      end
      checks++; if (an1 !== exp_an(slot_of(1)) || bcd1 !== exp_bcd(slot_of(1))) begin
        failures++; $display("FAIL scan_div1 got=%b/%h exp=%b/%h", an1, bcd1, exp_an(slot_of(1)), exp_bcd(slot_of(1)));
      end
    end
  endtask

  task automatic test_blank;
    int targets[3] = '{7, 0, 107};
    blank_lz = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step(0, 0, 0, 1);
      for (int i = 0; i < targets[t]; i++) step(0, 1, 1, 0);
      for (int i = 0; i < 4 * DIV; i++) begin
        step(0, 0, 0, 0);
        checks++; if (an !== exp_an(slot_of(DIV)) || bcd !== exp_bcd(slot_of(DIV))) begin
          failures++; $display("FAIL blank_%0d got=%b/%h exp=%b/%h", targets[t], an, bcd, exp_an(slot_of(DIV)), exp_bcd(slot_of(DIV)));
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    int guard = 0;
    blank_lz = 1'b0;
    while (!(slot_of(DIV) == 2 && ticks % DIV == 1) && guard < 64) begin
      step(0, 1, 1, 0);
      guard++;
    end
    checks++; if (guard >= 64) begin failures++; $display("FAIL midscan_reach got=timeout exp=slot2"); end
    step(1, 1, 1, 0);
    for (int i = 0; i < DIV; i++) begin
      checks++; if (an !== 4'b1110 || bcd !== 4'h0 || value !== 16'h0000 || wrap !== 1'b0) begin
        failures++; $display("FAIL midscan_slot0 got=%b/%h/%h exp=1110/0/0000", an, bcd, value);
      end
      step(0, 0, 0, 0);
    end
    checks++; if (an !== 4'b1101) begin failures++; $display("FAIL midscan_slot1 got=%b exp=1101", an); end
  endtask

  task automatic test_random;
    logic [15:0] e;
    for (int i = 0; i < 3000; i++) begin
      blank_lz = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0));
      exp_q.push_back(to_bcd(m_cnt));
      e = exp_q.pop_front();
      checks++; if (value !== e) begin failures++; $display("FAIL rand_value got=%h exp=%h", value, e); end
      checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL rand_wrap got=%b exp=%b", wrap, m_wrap); end
      checks++; if (an !== exp_an(slot_of(DIV)) || bcd !== exp_bcd(slot_of(DIV))) begin
        failures++; $display("FAIL rand_scan got=%b/%h exp=%b/%h", an, bcd, exp_an(slot_of(DIV)), exp_bcd(slot_of(DIV)));
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; blank_lz = 1'b0;
    test_reset();
    test_wrap();
    test_carry();
    test_priority();
    test_scan();
    test_blank();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
